// File: rtl/trend_predictor_table.sv
// trend_predictor_table
//   Branch-direction predictor table. Each of 2^INDEX_WIDTH entries holds a
//   signed saturating trend counter and the last resolved direction. When
//   consecutive outcomes agree the counter moves by 2 instead of 1. A global
//   saturating statistics counter tracks prediction quality and gates use of
//   the predictor through use_prediction.
//
//   After reset the table is cleared by a sweep of DEPTH cycles (INIT). Once
//   the sweep finishes, ready rises and lookups and updates are accepted.
//
// Ports
//   clk             clock, all state on rising edge
//   rst_n           synchronous active-low reset
//   ready           table initialised
//   pred_valid      lookup request
//   pred_index      lookup entry
//   pred_resp_valid response valid, one cycle after an accepted request
//   pred_taken      predicted direction (counter >= 0)
//   pred_confident  counter magnitude at or above CONF_THRESHOLD
//   upd_valid       resolved-branch update
//   upd_index       entry to update
//   upd_taken       actual direction
//   upd_mispredict  prediction used for this branch was wrong
//   stat_count      statistics counter
//   stat_of         one-cycle pulse on statistics overflow
//   use_prediction  stat_count >= STAT_THRESHOLD (registered)
module trend_predictor_table #(
    parameter int INDEX_WIDTH        = 6,
    parameter int CNT_WIDTH          = 3,
    parameter int CONF_THRESHOLD     = 2,
    parameter int STAT_COUNTER_WIDTH = 5,
    parameter int STAT_THRESHOLD     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          ready,
    input  logic                          pred_valid,
    input  logic [INDEX_WIDTH-1:0]        pred_index,
    output logic                          pred_resp_valid,
    output logic                          pred_taken,
    output logic                          pred_confident,
    input  logic                          upd_valid,
    input  logic [INDEX_WIDTH-1:0]        upd_index,
    input  logic                          upd_taken,
    input  logic                          upd_mispredict,
    output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
    output logic                          stat_of,
    output logic                          use_prediction
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    typedef logic signed [CNT_WIDTH-1:0] cnt_t;
    // One bit wider than the counter so add/sub cannot wrap before clamping.
    typedef logic signed [CNT_WIDTH:0]   wide_t;

    localparam wide_t CNT_MAX_W  = wide_t'((1 << (CNT_WIDTH - 1)) - 1);
    localparam wide_t CNT_MIN_W  = -wide_t'(1 << (CNT_WIDTH - 1));
    localparam wide_t CONF_POS_W = wide_t'(CONF_THRESHOLD);
    localparam wide_t CONF_NEG_W = -CONF_POS_W - wide_t'(1'b1);

    localparam logic [INDEX_WIDTH-1:0]        LAST_PTR     = {INDEX_WIDTH{1'b1}};
    localparam logic [STAT_COUNTER_WIDTH-1:0] STAT_MAX     = {STAT_COUNTER_WIDTH{1'b1}};
    localparam logic [STAT_COUNTER_WIDTH-1:0] STAT_HALF    = {1'b1, {(STAT_COUNTER_WIDTH-1){1'b0}}};
    localparam logic [STAT_COUNTER_WIDTH-1:0] STAT_PENALTY = STAT_COUNTER_WIDTH'(3);
    localparam logic [STAT_COUNTER_WIDTH-1:0] STAT_ONE     = STAT_COUNTER_WIDTH'(1);
    localparam logic [STAT_COUNTER_WIDTH-1:0] STAT_THR     = STAT_COUNTER_WIDTH'(STAT_THRESHOLD);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Next trend counter: step 2 when the outcome repeats the last direction,
    // computed one bit wider and clamped to the signed counter range.
    function automatic cnt_t next_cnt(input cnt_t cnt, input logic dir, input logic taken);
        wide_t ext;
        wide_t step;
        wide_t sum;
        ext  = wide_t'(cnt);
        step = (taken == dir) ? wide_t'(2'd2) : wide_t'(2'd1);
        if (taken) begin
            sum = ext + step;
            if (sum > CNT_MAX_W) begin
                sum = CNT_MAX_W;
            end else begin
                sum = sum;
            end
        end else begin
            sum = ext - step;
            if (sum < CNT_MIN_W) begin
                sum = CNT_MIN_W;
            end else begin
                sum = sum;
            end
        end
        return cnt_t'(sum);
    endfunction

    // Confidence: counter at or beyond the threshold in either direction.
    function automatic logic is_confident(input cnt_t cnt);
        wide_t ext;
        ext = wide_t'(cnt);
        return (ext >= CONF_POS_W) || (ext <= CONF_NEG_W);
    endfunction

    state_t                          state_r;
    state_t                          state_next_s;
    logic [INDEX_WIDTH-1:0]          ptr_r;
    cnt_t                            cnt_mem_r [DEPTH];
    logic                            dir_mem_r [DEPTH];

    logic                            ready_r;
    logic                            resp_valid_r;
    logic                            resp_taken_r;
    logic                            resp_conf_r;
    logic [STAT_COUNTER_WIDTH-1:0]   stat_r;
    logic                            stat_of_r;
    logic                            use_pred_r;

    logic                            run_s;
    logic                            upd_fire_s;
    logic                            pred_fire_s;
    cnt_t                            upd_cnt_s;
    cnt_t                            look_cnt_s;
    logic [STAT_COUNTER_WIDTH-1:0]   stat_next_s;
    logic                            stat_of_next_s;

    assign run_s       = (state_r == ST_RUN);
    assign upd_fire_s  = upd_valid && run_s;
    assign pred_fire_s = pred_valid && run_s;

    // FSM next state: sweep until the last entry is cleared, then run.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (ptr_r == LAST_PTR) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Updated entry value and lookup value with same-index bypass.
    always_comb begin
        upd_cnt_s  = next_cnt(cnt_mem_r[upd_index], dir_mem_r[upd_index], upd_taken);
        look_cnt_s = cnt_mem_r[pred_index];
        if (upd_fire_s && (upd_index == pred_index)) begin
            look_cnt_s = upd_cnt_s;
        end else begin
            look_cnt_s = cnt_mem_r[pred_index];
        end
    end

    // Statistics next value: +1 on correct (wrapping into the upper half with
    // an overflow pulse), -3 floored at zero on mispredict.
    always_comb begin
        stat_next_s    = stat_r;
        stat_of_next_s = 1'b0;
        if (upd_fire_s) begin
            if (upd_mispredict) begin
                if (stat_r < STAT_PENALTY) begin
                    stat_next_s = {STAT_COUNTER_WIDTH{1'b0}};
                end else begin
                    stat_next_s = stat_r - STAT_PENALTY;
                end
            end else if (stat_r == STAT_MAX) begin
                stat_next_s    = STAT_HALF;
                stat_of_next_s = 1'b1;
            end else begin
                stat_next_s = stat_r + STAT_ONE;
            end
        end else begin
            stat_next_s = stat_r;
        end
    end

    // Control, response and statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            ptr_r        <= {INDEX_WIDTH{1'b0}};
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_taken_r <= 1'b0;
            resp_conf_r  <= 1'b0;
            stat_r       <= {STAT_COUNTER_WIDTH{1'b0}};
            stat_of_r    <= 1'b0;
            use_pred_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ready_r      <= (state_next_s == ST_RUN);
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + 1'b1;
            end
            resp_valid_r <= pred_fire_s;
            if (pred_fire_s) begin
                resp_taken_r <= ~look_cnt_s[CNT_WIDTH-1];
                resp_conf_r  <= is_confident(look_cnt_s);
            end
            stat_r       <= stat_next_s;
            stat_of_r    <= stat_of_next_s;
            use_pred_r   <= (stat_next_s >= STAT_THR);
        end
    end

    // Table storage: cleared entry by entry during INIT, trained in RUN.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            cnt_mem_r[ptr_r] <= {CNT_WIDTH{1'b0}};
            dir_mem_r[ptr_r] <= 1'b0;
        end else if (upd_fire_s) begin
            cnt_mem_r[upd_index] <= upd_cnt_s;
            dir_mem_r[upd_index] <= upd_taken;
        end
    end

    assign ready           = ready_r;
    assign pred_resp_valid = resp_valid_r;
    assign pred_taken      = resp_taken_r;
    assign pred_confident  = resp_conf_r;
    assign stat_count      = stat_r;
    assign stat_of         = stat_of_r;
    assign use_prediction  = use_pred_r;

endmodule

// File: tb/tb_trend_predictor_table.sv
// Self-checking bench for trend_predictor_table (default parameters).
// A behavioural model holds each entry's counter as a plain integer and the
// statistics as an integer; DUT outputs are compared #1 after each edge.
module tb_trend_predictor_table;

    localparam int IW    = 6;
    localparam int CW    = 3;
    localparam int CONF  = 2;
    localparam int SW    = 5;
    localparam int STHR  = 8;
    localparam int DEPTH = 1 << IW;
    localparam int CMAX  = (1 << (CW - 1)) - 1;
    localparam int CMIN  = -(1 << (CW - 1));
    localparam int SMAX  = (1 << SW) - 1;
    localparam int SHALF = 1 << (SW - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ready;
    logic          pred_valid = 1'b0;
    logic [IW-1:0] pred_index = '0;
    logic          pred_resp_valid;
    logic          pred_taken;
    logic          pred_confident;
    logic          upd_valid = 1'b0;
    logic [IW-1:0] upd_index = '0;
    logic          upd_taken = 1'b0;
    logic          upd_mispredict = 1'b0;
    logic [SW-1:0] stat_count;
    logic          stat_of;
    logic          use_prediction;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int cnt_m [DEPTH];
    bit dir_m [DEPTH];
    int stat_m;
    bit ready_m;
    int init_left;
    bit exp_valid, exp_taken, exp_conf, exp_of;

    trend_predictor_table #(
        .INDEX_WIDTH(IW), .CNT_WIDTH(CW), .CONF_THRESHOLD(CONF),
        .STAT_COUNTER_WIDTH(SW), .STAT_THRESHOLD(STHR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .pred_valid(pred_valid), .pred_index(pred_index),
        .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken),
        .pred_confident(pred_confident),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict),
        .stat_count(stat_count), .stat_of(stat_of), .use_prediction(use_prediction)
    );

    always #5 clk = ~clk;

    task automatic model_update(input int ui, input bit ut, input bit um);
        int step;
        step = (ut == dir_m[ui]) ? 2 : 1;
        if (ut) cnt_m[ui] = (cnt_m[ui] + step > CMAX) ? CMAX : cnt_m[ui] + step;
        else    cnt_m[ui] = (cnt_m[ui] - step < CMIN) ? CMIN : cnt_m[ui] - step;
        dir_m[ui] = ut;
        if (um) begin
            stat_m = (stat_m < 3) ? 0 : stat_m - 3;
        end else if (stat_m == SMAX) begin
            stat_m = SHALF;
            exp_of = 1'b1;
        end else begin
            stat_m = stat_m + 1;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, step past the edge.
    task automatic cycle(input bit pv, input int pi, input bit uv, input int ui,
                         input bit ut, input bit um);
        pred_valid = pv; pred_index = pi[IW-1:0];
        upd_valid = uv; upd_index = ui[IW-1:0]; upd_taken = ut; upd_mispredict = um;
        exp_of = 1'b0;
        if (ready_m) begin
            if (uv) model_update(ui, ut, um);
            if (pv) begin
                exp_taken = (cnt_m[pi] >= 0);
                exp_conf  = (cnt_m[pi] >= CONF) || (cnt_m[pi] <= -CONF - 1);
            end
            exp_valid = pv;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk); #1;
        if (!ready_m) begin
            init_left = init_left - 1;
            if (init_left == 0) ready_m = 1'b1;
        end
        pred_valid = 1'b0; upd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pred_valid = 1'b0; upd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin cnt_m[i] = 0; dir_m[i] = 1'b0; end
        stat_m = 0; ready_m = 1'b0; init_left = DEPTH;
        exp_valid = 1'b0; exp_taken = 1'b0; exp_conf = 1'b0; exp_of = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 2 * DEPTH && !ready_m; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if ({ready, pred_resp_valid, pred_taken, pred_confident, stat_count, stat_of, use_prediction} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {ready, pred_resp_valid, pred_taken, pred_confident, stat_count, stat_of, use_prediction});
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, $urandom_range(0, DEPTH - 1), 1, $urandom_range(0, DEPTH - 1), 1'b1, 1'b0);
            total++; if (ready !== (i == DEPTH - 1)) begin
                bad++; $display("FAIL init_ready cycle=%0d got=%b exp=%b", i + 1, ready, (i == DEPTH - 1));
            end
            total++; if (pred_resp_valid !== 1'b0 || stat_count !== '0) begin
                bad++; $display("FAIL init_ignored cycle=%0d valid=%b stat=%0d exp valid=0 stat=0", i + 1, pred_resp_valid, stat_count);
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1, $urandom_range(0, DEPTH - 1), 0, 0, 0, 0);
            total++; if ({pred_resp_valid, pred_taken, pred_confident} !== 3'b110) begin
                bad++; $display("FAIL fresh_lookup got=%b exp=110", {pred_resp_valid, pred_taken, pred_confident});
            end
        end
    endtask

    task automatic test_train_taken();
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, 5, 1'b1, 1'b0);
            cycle(1, 5, 0, 0, 0, 0);
            total++; if ({pred_resp_valid, pred_taken, pred_confident} !== {exp_valid, exp_taken, exp_conf}) begin
                bad++; $display("FAIL train_taken step=%0d got=%b exp=%b", k, {pred_resp_valid, pred_taken, pred_confident}, {exp_valid, exp_taken, exp_conf});
            end
        end
        total++; if ({pred_taken, pred_confident} !== 2'b11) begin
            bad++; $display("FAIL taken_saturated got=%b exp=11", {pred_taken, pred_confident});
        end
    endtask

    task automatic test_train_not_taken();
        // Each update carries a same-cycle lookup on the same index (bypass).
        for (int k = 0; k < 4; k++) begin
            cycle(1, 5, 1, 5, 1'b0, 1'b1);
            total++; if ({pred_resp_valid, pred_taken, pred_confident} !== {exp_valid, exp_taken, exp_conf}) begin
                bad++; $display("FAIL bypass_not_taken step=%0d got=%b exp=%b", k, {pred_resp_valid, pred_taken, pred_confident}, {exp_valid, exp_taken, exp_conf});
            end
        end
        cycle(1, 5, 0, 0, 0, 0);
        total++; if ({pred_resp_valid, pred_taken, pred_confident} !== 3'b101) begin
            bad++; $display("FAIL not_taken_saturated got=%b exp=101", {pred_resp_valid, pred_taken, pred_confident});
        end
    endtask

    task automatic test_stats();
        apply_reset();
        wait_init();
        for (int k = 0; k < 31; k++) begin
            cycle(0, 0, 1, $urandom_range(0, DEPTH - 1), 1'($urandom), 1'b0);
            total++; if (stat_count !== SW'(stat_m) || stat_of !== exp_of || use_prediction !== (stat_m >= STHR)) begin
                bad++; $display("FAIL stat_count_up k=%0d got=%0d/%b/%b exp=%0d/%b/%b", k, stat_count, stat_of, use_prediction, stat_m, exp_of, (stat_m >= STHR));
            end
        end
        total++; if (stat_count !== 5'd31 || use_prediction !== 1'b1) begin
            bad++; $display("FAIL stat_max got=%0d use=%b exp=31 use=1", stat_count, use_prediction);
        end
        cycle(0, 0, 1, 3, 1'b1, 1'b0);
        total++; if (stat_count !== 5'd16 || stat_of !== 1'b1) begin
            bad++; $display("FAIL stat_overflow got=%0d of=%b exp=16 of=1", stat_count, stat_of);
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++; if (stat_of !== 1'b0 || stat_count !== 5'd16) begin
            bad++; $display("FAIL stat_of_pulse got=%b cnt=%0d exp=0 cnt=16", stat_of, stat_count);
        end
        // 16 -> 1 via five mispredicts, then +1 to 2, then one mispredict floors at 0
        for (int k = 0; k < 7; k++) begin
            cycle(0, 0, 1, $urandom_range(0, DEPTH - 1), 1'($urandom), (k != 5));
            total++; if (stat_count !== SW'(stat_m) || use_prediction !== (stat_m >= STHR)) begin
                bad++; $display("FAIL stat_down k=%0d got=%0d/%b exp=%0d/%b", k, stat_count, use_prediction, stat_m, (stat_m >= STHR));
            end
        end
        total++; if (stat_count !== 5'd0) begin
            bad++; $display("FAIL stat_floor got=%0d exp=0", stat_count);
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 9, 1'b0, 1'b0);
        cycle(1, 9, 0, 0, 0, 0);
        total++; if ({pred_taken, pred_confident} !== 2'b01) begin
            bad++; $display("FAIL idx9_trained got=%b exp=01", {pred_taken, pred_confident});
        end
        apply_reset();
        total++; if (ready !== 1'b0 || stat_count !== '0) begin
            bad++; $display("FAIL mid_reset_drop ready=%b stat=%0d exp ready=0 stat=0", ready, stat_count);
        end
        wait_init();
        total++; if (ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset_ready got=%b exp=1", ready);
        end
        cycle(1, 9, 0, 0, 0, 0);
        total++; if ({pred_resp_valid, pred_taken, pred_confident} !== 3'b110 || stat_count !== '0) begin
            bad++; $display("FAIL idx9_cleared got=%b stat=%0d exp=110 stat=0", {pred_resp_valid, pred_taken, pred_confident}, stat_count);
        end
    endtask

    task automatic test_back_to_back();
        int ui;
        for (int i = 0; i < DEPTH + 40; i++) begin
            int pi;
            pi = (i < DEPTH) ? i : $urandom_range(0, DEPTH - 1);
            // Other index for the first sweep; anything (including same) after.
            ui = (i < DEPTH) ? (i + $urandom_range(1, DEPTH - 1)) % DEPTH : $urandom_range(0, 7);
            if (i >= DEPTH) pi = $urandom_range(0, 7);
            cycle(1, pi, 1'($urandom), ui, 1'($urandom), 1'($urandom));
            total++; if ({pred_resp_valid, pred_taken, pred_confident} !== {1'b1, exp_taken, exp_conf}) begin
                bad++; $display("FAIL b2b_resp i=%0d idx=%0d got=%b exp=%b", i, pi, {pred_resp_valid, pred_taken, pred_confident}, {1'b1, exp_taken, exp_conf});
            end
            total++; if (stat_count !== SW'(stat_m) || stat_of !== exp_of || use_prediction !== (stat_m >= STHR)) begin
                bad++; $display("FAIL b2b_stat i=%0d got=%0d/%b/%b exp=%0d/%b/%b", i, stat_count, stat_of, use_prediction, stat_m, exp_of, (stat_m >= STHR));
            end
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++; if ({pred_resp_valid, pred_taken, pred_confident} !== {1'b0, exp_taken, exp_conf}) begin
            bad++; $display("FAIL idle_hold got=%b exp=%b", {pred_resp_valid, pred_taken, pred_confident}, {1'b0, exp_taken, exp_conf});
        end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_train_not_taken();
        test_stats();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
